// File: rtl/upa2_seq.sv
// G.726 UPA2 stage: multi-cycle computation of the unlimited second-order
// predictor coefficient A2T, with internal PK1/PK2 sign history.
module upa2_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        scan_in0,
    input  logic        scan_in1,
    input  logic        scan_in2,
    input  logic        scan_in3,
    input  logic        scan_in4,
    input  logic        scan_enable,
    input  logic        test_mode,
    input  logic        start,
    input  logic        PK0,
    input  logic        SIGPK,
    input  logic [15:0] A1,
    input  logic [15:0] A2,
    output logic        scan_out0,
    output logic        scan_out1,
    output logic        scan_out2,
    output logic        scan_out3,
    output logic        scan_out4,
    output logic        ready,
    output logic        done,
    output logic [15:0] A2T
);

    // state  | meaning
    // IDLE   | ready, waiting for start; operands captured on accept
    // FA     | sign products, FA and UGA2B = UGA2A + FA
    // UGA    | UGA2 (gain term) and ULA2 (leak term)
    // SUM    | UA2 and A2T; A2T and PK history update on exit
    // DONE   | done pulse, A2T valid
    typedef enum logic [2:0] {
        S_IDLE,
        S_FA,
        S_UGA,
        S_SUM,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic        pk0_r;
    logic        sigpk_r;
    logic [15:0] a1_r;
    logic [15:0] a2_r;
    logic        pk1;
    logic        pk2;
    logic [16:0] uga2b_r;
    logic [16:0] uga2_r;
    logic [15:0] ula2_r;

    logic        pks1;
    logic        pks2;
    logic [16:0] uga2a;
    logic [16:0] a1_x4;
    logic [16:0] fa1;
    logic [16:0] fa;
    logic [16:0] uga2b_shr;
    logic [15:0] a2_shr;
    logic [15:0] ula2;
    logic [16:0] uga2;
    logic [16:0] add_a;
    logic [16:0] add_b;
    logic [16:0] add_sum;

    assign scan_out0 = test_mode & scan_enable & scan_in0;
    assign scan_out1 = test_mode & scan_enable & scan_in1;
    assign scan_out2 = test_mode & scan_enable & scan_in2;
    assign scan_out3 = test_mode & scan_enable & scan_in3;
    assign scan_out4 = test_mode & scan_enable & scan_in4;

    assign ready = (state == S_IDLE);
    assign done  = (state == S_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_FA;
            S_FA:    state_nx = S_UGA;
            S_UGA:   state_nx = S_SUM;
            S_SUM:   state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign pks1  = pk0_r ^ pk1;
    assign pks2  = pk0_r ^ pk2;
    assign uga2a = pks2 ? 17'd114688 : 17'd16384;
    assign a1_x4 = {1'b0, a1_r} << 2;

    always_comb begin
        fa1 = 17'd0;
        if (!a1_r[15]) begin
            fa1 = (a1_r <= 16'd8191) ? a1_x4 : 17'd32764;
        end else begin
            fa1 = (a1_r >= 16'd57345) ? a1_x4 : 17'd98308;
        end
    end

    // 131072 - FA1 modulo 2^17 is plain two's complement negation
    assign fa        = pks1 ? fa1 : (17'd0 - fa1);
    assign uga2b_shr = uga2b_r >> 7;
    assign a2_shr    = a2_r >> 7;
    assign ula2      = a2_r[15] ? (16'd0 - (a2_shr + 16'd65024)) : (16'd0 - a2_shr);

    // One adder serves the 17-bit gain path in every arithmetic state
    always_comb begin
        add_a = 17'd0;
        add_b = 17'd0;
        case (state)
            S_FA: begin
                add_a = uga2a;
                add_b = fa;
            end
            S_UGA: begin
                add_a = uga2b_shr;
                add_b = 17'd126976;
            end
            S_SUM: begin
                add_a = uga2_r;
                add_b = {1'b0, ula2_r};
            end
            default: begin
                add_a = 17'd0;
                add_b = 17'd0;
            end
        endcase
    end

    assign add_sum = add_a + add_b;
    assign uga2    = sigpk_r ? 17'd0 : (uga2b_r[16] ? add_sum : uga2b_shr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pk0_r   <= 1'b0;
            sigpk_r <= 1'b0;
            a1_r    <= 16'd0;
            a2_r    <= 16'd0;
            pk1     <= 1'b0;
            pk2     <= 1'b0;
            uga2b_r <= 17'd0;
            uga2_r  <= 17'd0;
            ula2_r  <= 16'd0;
            A2T     <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pk0_r   <= PK0;
                        sigpk_r <= SIGPK;
                        a1_r    <= A1;
                        a2_r    <= A2;
                    end
                end
                S_FA: begin
                    uga2b_r <= add_sum;
                end
                S_UGA: begin
                    uga2_r <= uga2;
                    ula2_r <= ula2;
                end
                S_SUM: begin
                    // A2T is already updated while done is high
                    A2T <= a2_r + add_sum[15:0];
                    pk2 <= pk1;
                    pk1 <= pk0_r;
                end
                default: ;
            endcase
        end
    end

endmodule
